// File: rtl/coherence_bus_ctrl.sv
// Two-cache snooping bus controller with a shared RAM port.
// A read miss snoops the other cache. A Modified block comes from the other
// cache through the FWD states and is also written to RAM. Otherwise the block
// is loaded from RAM. A dirty eviction goes straight to RAM through WB.
// Each block has two words, and the requester's daddr bit 2 selects the word.
// Build option: define BUS_RR_ARB_EN for round-robin arbitration.
// Without it, cache 0 has fixed priority.
module coherence_bus_ctrl (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       cctrans,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate
);

    typedef enum logic [3:0] {
        IDLE, ARB, SNOOP, FWD0, FWD1, LD0, LD1, WB0, WB1
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t     state, next_state;
    logic       req_q, req_d;      // granted requester r
    logic       inv_q, inv_d;      // snooped block must be invalidated
    logic       winner;
    logic       xfer_done;         // last word of a transaction completes
    logic       s;                 // snooper, always the other cache
    logic [1:0] req_vec;
    logic       access;

    assign req_vec = dREN | dWEN;
    assign s       = ~req_q;
    assign access  = (ramstate == RAM_ACCESS);

`ifdef BUS_RR_ARB_EN
    logic ptr_q;

    // The pointer cache wins if it requests. Otherwise the other cache wins.
    assign winner = req_vec[ptr_q] ? ptr_q : ~ptr_q;

    // After each completed transaction, the pointer moves away from the cache just served.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)          ptr_q <= 1'b0;
        else if (xfer_done) ptr_q <= ~req_q;
    end
`else
    // Fixed priority: cache 0 wins whenever it requests.
    assign winner = ~req_vec[0];
`endif

    // State register plus the latched requester and invalidate intent.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= next_state;
            req_q <= req_d;
            inv_q <= inv_d;
        end
    end

    // Next-state logic and all bus and RAM outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        next_state  = state;
        req_d       = req_q;
        inv_d       = inv_q;
        xfer_done   = 1'b0;
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                if (|req_vec) next_state = ARB;
            end
            ARB: begin
                req_d = winner;
                if (dWEN[winner])      next_state = WB0;
                else if (dREN[winner]) next_state = SNOOP;
                else                   next_state = IDLE;
            end
            SNOOP: begin
                ccwait[s]      = 1'b1;
                ccinv[s]       = ccwrite[req_q];
                ccsnoopaddr[s] = daddr[req_q];
                inv_d          = ccwrite[req_q];
                next_state     = (cctrans[s] & ccwrite[s]) ? FWD0 : LD0;
            end
            FWD0, FWD1: begin
                ccwait[s]      = 1'b1;
                ccinv[s]       = inv_q;
                ccsnoopaddr[s] = daddr[req_q];
                ramWEN         = 1'b1;
                ramaddr        = daddr[req_q];
                ramstore       = dstore[s];
                dload[req_q]   = dstore[s];
                if (access) begin
                    dwait      = 2'b00;
                    next_state = (state == FWD0) ? FWD1 : IDLE;
                    xfer_done  = (state == FWD1);
                end
            end
            LD0, LD1: begin
                ccwait[s]      = 1'b1;
                ccinv[s]       = inv_q;
                ccsnoopaddr[s] = daddr[req_q];
                ramREN         = 1'b1;
                ramaddr        = daddr[req_q];
                dload[req_q]   = ramload;
                if (access) begin
                    dwait[req_q] = 1'b0;
                    next_state   = (state == LD0) ? LD1 : IDLE;
                    xfer_done    = (state == LD1);
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = dstore[req_q];
                if (access) begin
                    dwait[req_q] = 1'b0;
                    next_state   = (state == WB0) ? WB1 : IDLE;
                    xfer_done    = (state == WB1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl. A table of per-cycle vectors covers
// the read, forward and writeback paths. Hand-written sequences then cover
// arbitration and a reset asserted in the middle of a transaction.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait),
        .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  dren, dwen;
        logic [31:0] daddr0, daddr1, dstore0, dstore1;
        logic [1:0]  cctrans, ccwrite;
        logic [31:0] ramload;
        logic [1:0]  ramstate;
    } ins_t;

    typedef struct packed {
        logic [1:0]  dwait;
        logic [31:0] dload0, dload1;
        logic [1:0]  ccwait, ccinv;
        logic [31:0] snoop0, snoop1;
        logic        ren, wen;
        logic [31:0] addr, store;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t o;
    } vec_t;

    vec_t  vecs[$];
    int    passed = 0;
    int    total  = 0;
    ins_t  in0;
    outs_t def_o;

    function automatic ins_t mi(logic [1:0] dren, logic [1:0] dwen, logic [31:0] a0,
                                logic [31:0] a1, logic [31:0] s0, logic [31:0] s1,
                                logic [1:0] ct, logic [1:0] cw, logic [31:0] rl,
                                logic [1:0] rs);
        ins_t v;
        v.dren = dren; v.dwen = dwen; v.daddr0 = a0; v.daddr1 = a1;
        v.dstore0 = s0; v.dstore1 = s1; v.cctrans = ct; v.ccwrite = cw;
        v.ramload = rl; v.ramstate = rs;
        return v;
    endfunction

    function automatic outs_t mo(logic [1:0] dw, logic [31:0] dl0, logic [31:0] dl1,
                                 logic [1:0] cw, logic [1:0] ci, logic [31:0] sn0,
                                 logic [31:0] sn1, logic ren, logic wen,
                                 logic [31:0] addr, logic [31:0] store);
        outs_t v;
        v.dwait = dw; v.dload0 = dl0; v.dload1 = dl1; v.ccwait = cw; v.ccinv = ci;
        v.snoop0 = sn0; v.snoop1 = sn1; v.ren = ren; v.wen = wen;
        v.addr = addr; v.store = store;
        return v;
    endfunction

    function automatic outs_t sample();
        return mo(dwait, dload[0], dload[1], ccwait, ccinv, ccsnoopaddr[0],
                  ccsnoopaddr[1], ramREN, ramWEN, ramaddr, ramstore);
    endfunction

    task automatic apply(input ins_t v);
        dREN = v.dren; dWEN = v.dwen; daddr[0] = v.daddr0; daddr[1] = v.daddr1;
        dstore[0] = v.dstore0; dstore[1] = v.dstore1; cctrans = v.cctrans;
        ccwrite = v.ccwrite; ramload = v.ramload; ramstate = v.ramstate;
    endtask

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input string n, input ins_t i, input outs_t o);
        vecs.push_back('{n, i, o});
    endtask

    // Both caches request reads. Check the grant in SNOOP and the word handshakes in LD0 and LD1.
    task automatic both_read(input string tag, input logic exp_r);
        logic [1:0] win_wait;
        win_wait = exp_r ? 2'b01 : 2'b10;
        @(negedge CLK); apply(mi(2'b11, 2'b00, 'h400, 'h500, 0, 0, 0, 0, 'h77, ACCESS));
        @(negedge CLK);
        @(negedge CLK); #1;
        check({tag, " grant ccwait"}, ccwait, exp_r ? 2'b01 : 2'b10);
        @(negedge CLK); #1;
        check({tag, " ld0 dwait"}, dwait, win_wait);
        @(negedge CLK); #1;
        check({tag, " ld1 dload"}, dload[exp_r], 32'h77);
    endtask

    initial begin
        logic exp_second;
        in0   = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, FREE);
        def_o = mo(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Cache 0 read miss. Cache 1 has no copy. RAM answers after two BUSY cycles.
        add("rd idle",   mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h11111111, BUSY), def_o);
        add("rd arb",    mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h11111111, BUSY), def_o);
        add("rd snoop",  mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h11111111, BUSY),
            mo(2'b11, 0, 0, 2'b10, 2'b00, 0, 'h100, 0, 0, 0, 0));
        add("rd ld0 b1", mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h11111111, BUSY),
            mo(2'b11, 'h11111111, 0, 2'b10, 0, 0, 'h100, 1, 0, 'h100, 0));
        add("rd ld0 b2", mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h11111111, BUSY),
            mo(2'b11, 'h11111111, 0, 2'b10, 0, 0, 'h100, 1, 0, 'h100, 0));
        add("rd ld0 acc", mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h11111111, ACCESS),
            mo(2'b10, 'h11111111, 0, 2'b10, 0, 0, 'h100, 1, 0, 'h100, 0));
        // Request dropped during LD1; the word still completes.
        add("rd ld1 acc", mi(2'b00, 0, 'h104, 0, 0, 0, 0, 0, 'h22222222, ACCESS),
            mo(2'b10, 'h22222222, 0, 2'b10, 0, 0, 'h104, 1, 0, 'h104, 0));
        add("rd done",   in0, def_o);

        // Cache 1 read-for-modify. Cache 0 holds the block Modified and forwards it.
        add("fw idle",   mi(2'b10, 0, 0, 'h200, 0, 0, 2'b00, 2'b10, 'h55555555, FREE), def_o);
        add("fw arb",    mi(2'b10, 0, 0, 'h200, 0, 0, 2'b00, 2'b10, 'h55555555, FREE), def_o);
        add("fw snoop",  mi(2'b10, 0, 0, 'h200, 0, 0, 2'b01, 2'b11, 'h55555555, FREE),
            mo(2'b11, 0, 0, 2'b01, 2'b01, 'h200, 0, 0, 0, 0, 0));
        add("fw0 acc",   mi(2'b10, 0, 0, 'h200, 'hDEADBEEF, 0, 2'b01, 2'b11, 'h55555555, ACCESS),
            mo(2'b00, 0, 'hDEADBEEF, 2'b01, 2'b01, 'h200, 0, 0, 1, 'h200, 'hDEADBEEF));
        add("fw1 busy",  mi(2'b10, 0, 0, 'h204, 'hCAFEF00D, 0, 2'b01, 2'b11, 'h55555555, BUSY),
            mo(2'b11, 0, 'hCAFEF00D, 2'b01, 2'b01, 'h204, 0, 0, 1, 'h204, 'hCAFEF00D));
        add("fw1 acc",   mi(2'b10, 0, 0, 'h204, 'hCAFEF00D, 0, 2'b01, 2'b11, 'h55555555, ACCESS),
            mo(2'b00, 0, 'hCAFEF00D, 2'b01, 2'b01, 'h204, 0, 0, 1, 'h204, 'hCAFEF00D));
        add("fw done",   in0, def_o);

        // Cache 0 dirty eviction. No snoop is issued. FREE and ERROR both hold WB1.
        add("wb idle",   mi(0, 2'b01, 'h300, 0, 'hAAAA0000, 0, 0, 0, 0, FREE), def_o);
        add("wb arb",    mi(0, 2'b01, 'h300, 0, 'hAAAA0000, 0, 0, 0, 0, FREE), def_o);
        add("wb0 acc",   mi(0, 2'b01, 'h300, 0, 'hAAAA0000, 0, 0, 0, 0, ACCESS),
            mo(2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 'h300, 'hAAAA0000));
        add("wb1 free",  mi(0, 2'b01, 'h304, 0, 'hBBBB1111, 0, 0, 0, 0, FREE),
            mo(2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 'h304, 'hBBBB1111));
        add("wb1 err",   mi(0, 2'b01, 'h304, 0, 'hBBBB1111, 0, 0, 0, 0, ERROR),
            mo(2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 'h304, 'hBBBB1111));
        add("wb1 acc",   mi(0, 2'b01, 'h304, 0, 'hBBBB1111, 0, 0, 0, 0, ACCESS),
            mo(2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 'h304, 'hBBBB1111));
        add("wb done",   in0, def_o);

        // Reset values while nRST is held low.
        nRST = 1'b0;
        apply(in0);
        #7;
        check("reset outputs", sample(), def_o);
        @(negedge CLK);
        nRST = 1'b1;

        // Table run, one vector per clock cycle.
        foreach (vecs[k]) begin
            @(negedge CLK);
            apply(vecs[k].i);
            #1;
            check(vecs[k].name, sample(), vecs[k].o);
        end

        // Arbitration between two simultaneous requests, starting from a fresh reset.
        @(negedge CLK); nRST = 1'b0; apply(in0);
        #1; check("arb reset outputs", sample(), def_o);
        @(negedge CLK); nRST = 1'b1;
`ifdef BUS_RR_ARB_EN
        exp_second = 1'b1;
`else
        exp_second = 1'b0;
`endif
        both_read("arb first", 1'b0);
        both_read("arb second", exp_second);

        // Reset asserted during LD1, followed by a normal request right after release.
        @(negedge CLK); apply(in0);
        @(negedge CLK); apply(mi(2'b01, 0, 'h100, 0, 0, 0, 0, 0, 'h99, ACCESS));
        @(negedge CLK);                 // ARB
        @(negedge CLK);                 // SNOOP
        @(negedge CLK);                 // LD0
        @(negedge CLK); #1;             // LD1
        check("mid ld1 dwait", dwait, 2'b10);
        #1 nRST = 1'b0;
        #1 check("reset in ld1", sample(), def_o);
        @(negedge CLK); nRST = 1'b1;    // request still held
        @(negedge CLK);                 // ARB
        @(negedge CLK); #1;
        check("post reset snoop", sample(), mo(2'b11, 0, 0, 2'b10, 0, 0, 'h100, 0, 0, 0, 0));
        @(negedge CLK); #1;
        check("post reset ld0", sample(), mo(2'b10, 'h99, 0, 2'b10, 0, 0, 'h100, 1, 0, 'h100, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
